// File: rtl/gate_sweep_ctrl.sv
// Gate sweep controller: drives the four 2-bit input vectors onto a gate under
// test, holds each for HOLD_CYCLES clocks, captures the gate output at the end
// of each hold window, and compares the captured truth table with EXPECTED.
// Optional feature macro: GATE_SWEEP_LOOP_EN (level-sensitive start with
// back-to-back sweeps). Without it, start is rising-edge detected.
module gate_sweep_ctrl #(
    parameter int unsigned HOLD_CYCLES = 100,
    parameter logic [3:0]  EXPECTED    = 4'b1000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic       dut_a_o,
    output logic       dut_b_o,
    input  logic       dut_c_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] result_o,
    output logic [2:0] err_cnt_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDrive = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  vec_q, vec_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  result_q, result_d;
    logic        pass_q, pass_d;
    logic [2:0]  err_q, err_d;
    logic        dut_a_q, dut_a_d;
    logic        dut_b_q, dut_b_d;
    logic        start_go;
    logic        done_restart;
    logic        begin_sweep;

`ifdef GATE_SWEEP_LOOP_EN
    // Level-sensitive start; a held start chains sweeps directly from DONE.
    assign start_go     = start_i;
    assign done_restart = start_i;
`else
    logic start_prev_q;

    // Previous start level for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_prev_q <= 1'b0;
        end else begin
            start_prev_q <= start_i;
        end
    end

    assign start_go     = start_i & ~start_prev_q;
    assign done_restart = 1'b0;
`endif

    // Next-state logic: sweep sequencing, capture and result evaluation.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        pass_d      = pass_q;
        err_d       = err_q;
        dut_a_d     = dut_a_q;
        dut_b_d     = dut_b_q;
        begin_sweep = 1'b0;

        case (state_q)
            StIdle: begin
                begin_sweep = start_go;
            end
            StDrive: begin
                if (cnt_q == HoldLast) begin
                    cnt_d           = 16'd0;
                    result_d[vec_q] = dut_c_i;
                    vec_d           = vec_q + 2'd1;
                    if (vec_q == 2'd3) begin
                        state_d = StDone;
                        dut_a_d = 1'b0;
                        dut_b_d = 1'b0;
                        // result_d already holds the final capture here.
                        pass_d  = (result_d == EXPECTED);
                        if ((result_d != EXPECTED) && (err_q != 3'd7)) begin
                            err_d = err_q + 3'd1;
                        end
                    end else begin
                        dut_a_d = vec_d[1];
                        dut_b_d = vec_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                state_d     = StIdle;
                begin_sweep = done_restart;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (begin_sweep) begin
            state_d  = StDrive;
            vec_d    = 2'd0;
            cnt_d    = 16'd0;
            result_d = 4'd0;
            pass_d   = 1'b0;
            dut_a_d  = 1'b0;
            dut_b_d  = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            vec_q    <= 2'd0;
            cnt_q    <= 16'd0;
            result_q <= 4'd0;
            pass_q   <= 1'b0;
            err_q    <= 3'd0;
            dut_a_q  <= 1'b0;
            dut_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            dut_a_q  <= dut_a_d;
            dut_b_q  <= dut_b_d;
        end
    end

    assign dut_a_o   = dut_a_q;
    assign dut_b_o   = dut_b_q;
    assign busy_o    = (state_q == StDrive);
    assign done_o    = (state_q == StDone);
    assign pass_o    = pass_q;
    assign result_o  = result_q;
    assign err_cnt_o = err_q;

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 100, cycles each input vector is held on the gate under test; legal range 1..65535.
REQ-002 Parameter EXPECTED, default 4'b1000 (AND), expected gate output; bit i corresponds to input vector {a,b}=i.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  sweep request.
REQ-006 dut_a  output  1  gate input a.
REQ-007 dut_b  output  1  gate input b.
REQ-008 dut_c  input  1  gate output, sampled by this block.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 pass  output  1  high when the last sweep result equals EXPECTED.
REQ-012 result  output  4  captured gate outputs, bit i for vector i.
REQ-013 err_cnt  output  3  count of failed sweeps since reset, saturating at 7.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, DRIVE, DONE.
REQ-015 In IDLE, an accepted start at edge k SHALL move the FSM to DRIVE: vec=0, hold counter=0, result=0, pass=0, busy=1.
REQ-016 dut_a SHALL equal vec[1] and dut_b SHALL equal vec[0], both registered; vec order SHALL be 00, 01, 10, 11.
REQ-017 In DRIVE, the hold counter SHALL increment each cycle; at the edge where it equals HOLD_CYCLES-1, dut_c SHALL be captured into result[vec], the counter SHALL clear, and vec SHALL increment.
REQ-018 Capturing vec=3 SHALL move the FSM to DONE; done SHALL rise at edge k+4*HOLD_CYCLES and stay high for exactly one cycle.
REQ-019 On DONE entry, busy SHALL go to 0 and dut_a/dut_b to 0. pass SHALL be set to (result==EXPECTED), including the final capture.
REQ-020 On a failed sweep, err_cnt SHALL increment by 1 on DONE entry, saturating at 7 with no wrap.
REQ-021 start SHALL be ignored in DRIVE and DONE; a sweep in progress SHALL never restart.
REQ-022 result and pass SHALL hold their values until the next accepted start.
REQ-023 HOLD_CYCLES=1 SHALL advance one vector per cycle, with no idle gap between vectors.

Reset
REQ-024 rst_n low SHALL, asynchronously and at any point including mid-sweep, set FSM=IDLE, vec=0, counter=0, dut_a=dut_b=busy=done=pass=0, result=0, err_cnt=0.
REQ-025 The first start after rst_n deasserts SHALL begin a full sweep at vector 00.

Configuration
REQ-026 Macro GATE_SWEEP_LOOP_EN defined: start is level-sensitive; in IDLE, start=1 SHALL begin a sweep. DONE SHALL go directly to DRIVE (new sweep, vec=0, result cleared) if start=1, else to IDLE.
REQ-027 Macro GATE_SWEEP_LOOP_EN undefined: start SHALL be rising-edge detected (registered previous value, reset to 0). Only a 0->1 transition seen in IDLE SHALL start a sweep, and DONE SHALL always go to IDLE.

Verification (HOLD_CYCLES=4, EXPECTED=4'b1000 unless stated)
REQ-028 Reset: hold rst_n=0, toggle start -> every output 0 and no sweep.
REQ-029 AND gate model, one start pulse -> dut_a/dut_b show 00,01,10,11 for 4 cycles each; done pulses at edge k+16; result=4'b1000, pass=1, err_cnt=0.
REQ-030 OR gate model, one start pulse -> result=4'b1110, pass=0, err_cnt=1.
REQ-031 Macro undefined, start held high for 40 cycles plus an extra pulse during busy -> exactly one sweep and one done pulse.
REQ-032 rst_n pulsed low while vec=2 -> outputs 0 immediately, before the next clk edge; the next start runs a full sweep from 00 and gives result=4'b1000.
REQ-033 Macro defined, XOR gate model (failing), start held high for 9 sweeps -> back-to-back sweeps with done every 17 cycles; err_cnt reaches 7 and stays at 7.
